// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter in front of the single-port Data_Memory.
// Each transaction runs IDLE -> ACCESS -> RESP -> IDLE. The winner gets a
// one-cycle gnt in ACCESS, and a one-cycle rvalid (with err) in the IDLE
// cycle that follows RESP.
module data_memory_arbiter #(
  parameter int MEMORY_DEPTH = 64,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic                  mem_enable,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  // state  | meaning
  // IDLE   | waiting for a request; also the rvalid/err cycle of the previous transaction
  // ACCESS | winner's gnt high; address/data presented, write enabled if legal
  // RESP   | memory read data valid for the latched address; captured at the edge
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEMORY_DEPTH);

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  winner_q, winner_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  range_err_q, range_err_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                  err0_q, err0_d, err1_q, err1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic                  pick;
  logic [DATA_WIDTH-1:0] resp_data;

  // Next-state, arbitration and registered-output computation
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    range_err_d  = range_err_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    // With both requesting, the port that did not win last time goes next.
    pick         = (req0 && req1) ? ~last_grant_q : req1;
    resp_data    = range_err_q ? '0 : mem_read_data;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          winner_d     = pick;
          last_grant_d = pick;
          we_d         = pick ? we1 : we0;
          addr_d       = pick ? addr1 : addr0;
          wdata_d      = pick ? wdata1 : wdata0;
          range_err_d  = (pick ? addr1 : addr0) >= DEPTH_W;
          gnt0_d       = ~pick;
          gnt1_d       = pick;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        state_d = ST_IDLE;
        if (winner_q) begin
          rdata1_d  = resp_data;
          rvalid1_d = 1'b1;
          err1_d    = range_err_q;
        end else begin
          rdata0_d  = resp_data;
          rvalid0_d = 1'b1;
          err0_d    = range_err_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      range_err_q  <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      range_err_q  <= range_err_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Memory-side drive; the write strobe is also gated by reset so a reset
  // landing on the ACCESS edge cannot commit the write.
  always_comb begin
    mem_enable     = (state_q == ST_ACCESS) && we_q && !range_err_q && reset;
    mem_address    = addr_q;
    mem_write_data = wdata_q;
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a registered-address memory model.
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_enable;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Data_Memory model: writes on Enable, read address registered every edge
  logic [31:0] ram [0:63];
  logic [31:0] ram_addr_q;
  logic        preload;
  logic        men_seen;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h1000_0000 + i;
    end else if (mem_enable && mem_address < 32'd64) begin
      ram[mem_address[5:0]] <= mem_write_data;
    end
    ram_addr_q <= mem_address;
  end

  assign mem_read_data = (ram_addr_q < 32'd64) ? ram[ram_addr_q[5:0]] : 32'h0;

  always @(negedge clk) if (mem_enable) men_seen <= 1'b1;

  data_memory_arbiter #(.MEMORY_DEPTH(64), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_enable(mem_enable), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // One transaction on port p; latencies counted in edges from the request edge.
  task automatic txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int lg, output int lv);
    int start;
    bit got;
    rd = '0; er = 1'b0; lg = -1; lv = -1;
    @(negedge clk);
    set_req(p, 1'b1, w, a, d);
    start = cyc;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? gnt0 : gnt1) begin
        got = 1;
        lg = cyc - start;
        set_req(p, 1'b0, 1'b0, '0, '0);
      end
    end
    if (!got) begin
      chk("txn_gnt_timeout", 32'd0, 32'd1);
      set_req(p, 1'b0, 1'b0, '0, '0);
      return;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? rvalid0 : rvalid1) begin
        got = 1;
        lv = cyc - start;
        rd = (p == 0) ? rdata0 : rdata1;
        er = (p == 0) ? err0 : err1;
      end
    end
    if (!got) chk("txn_rvalid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lg, lv;
    int          gp [8];
    int          gc [8];
    int          ng;
    bit          got;

    reset = 1'b0; preload = 1'b1; men_seen = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst_rvalid_err", {28'd0, err1, err0, rvalid1, rvalid0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
    reset = 1'b1; preload = 1'b0;

    // Both ports request continuously right after reset: 0,1,0,1 every 3 edges
    req0 = 1; we0 = 0; addr0 = 32'd10;
    req1 = 1; we1 = 0; addr1 = 32'd11;
    lg = cyc;
    ng = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt0 && gnt1) chk("t2_both_gnt", 32'd1, 32'd0);
      if (gnt0 && ng < 8) begin gp[ng] = 0; gc[ng] = cyc - lg; ng++; end
      if (gnt1 && ng < 8) begin gp[ng] = 1; gc[ng] = cyc - lg; ng++; end
      if (rvalid0) chk("t2_rdata0", rdata0, 32'h1000_000A);
      if (rvalid1) chk("t2_rdata1", rdata1, 32'h1000_000B);
    end
    req0 = 0; req1 = 0;
    chk("t2_num_gnts", ng, 32'd4);
    if (ng >= 4) begin
      chk("t2_first_gnt_lat", gc[0], 32'd1);
      for (int i = 0; i < 4; i++) chk("t2_gnt_port", gp[i], i % 2);
      for (int i = 1; i < 4; i++) chk("t2_gnt_spacing", gc[i] - gc[i-1], 32'd3);
    end
    repeat (5) @(negedge clk);

    // Single write then read on port 0
    txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF, rd, er, lg, lv);
    chk("t1_wr_gnt_lat", lg, 32'd1);
    chk("t1_wr_rvalid_lat", lv, 32'd3);
    chk("t1_wr_rdata", rd, 32'hDEAD_BEEF);
    chk("t1_wr_err", {31'd0, er}, 32'd0);
    txn(0, 1'b0, 32'd5, 32'd0, rd, er, lg, lv);
    chk("t1_rd_rdata", rd, 32'hDEAD_BEEF);
    chk("t1_rd_err", {31'd0, er}, 32'd0);

    // Out-of-range write on port 1 must never strobe the memory
    @(negedge clk); men_seen = 1'b0;
    txn(1, 1'b1, 32'd64, 32'h0000_1234, rd, er, lg, lv);
    chk("t3_err1", {31'd0, er}, 32'd1);
    chk("t3_rdata1", rd, 32'd0);
    chk("t3_mem_enable_seen", {31'd0, men_seen}, 32'd0);
    chk("t3_rdata0_kept", rdata0, 32'hDEAD_BEEF);
    txn(1, 1'b0, 32'd0, 32'd0, rd, er, lg, lv);
    chk("t3_addr0_unchanged", rd, 32'h1000_0000);
    chk("t3_addr0_err", {31'd0, er}, 32'd0);

    // Reset during the ACCESS cycle of a write
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 32'd7, 32'hA5A5_A5A5);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt0) got = 1;
    end
    if (!got) chk("t4_gnt_timeout", 32'd0, 32'd1);
    chk("t4_mem_enable_before", {31'd0, mem_enable}, 32'd1);
    reset = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("t4_mem_enable_gated", {31'd0, mem_enable}, 32'd0);
    @(negedge clk);
    chk("t4_outputs", {28'd0, gnt0, gnt1, rvalid0, rvalid1}, 32'd0);
    chk("t4_rdata0", rdata0, 32'd0);
    chk("t4_rdata1", rdata1, 32'd0);
    chk("t4_mem_address", mem_address, 32'd0);
    reset = 1'b1;
    lv = 0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid0 || rvalid1) lv++;
    end
    chk("t4_no_rvalid", lv, 32'd0);
    txn(0, 1'b0, 32'd7, 32'd0, rd, er, lg, lv);
    chk("t4_addr7_old", rd, 32'h1000_0007);

    // Top legal address on port 1, then an untouched address
    txn(1, 1'b1, 32'd63, 32'hCAFE_F00D, rd, er, lg, lv);
    chk("t5_wr63_rdata", rd, 32'hCAFE_F00D);
    chk("t5_wr63_err", {31'd0, er}, 32'd0);
    txn(1, 1'b0, 32'd63, 32'd0, rd, er, lg, lv);
    chk("t5_rd63_rdata", rd, 32'hCAFE_F00D);
    chk("t5_rd63_err", {31'd0, er}, 32'd0);
    txn(1, 1'b0, 32'd20, 32'd0, rd, er, lg, lv);
    chk("t5_rd20_preload", rd, 32'h1000_0014);

    // Port 0 re-requests in its rvalid cycle: next gnt on the following cycle
    txn(0, 1'b0, 32'd5, 32'd0, rd, er, lg, lv);
    chk("t6_first_rdata", rd, 32'hDEAD_BEEF);
    set_req(0, 1'b1, 1'b0, 32'd63, 32'd0);
    @(negedge clk);
    chk("t6_back_to_back_gnt", {31'd0, gnt0}, 32'd1);
    set_req(0, 1'b0, 1'b0, '0, '0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rvalid0) got = 1;
    end
    if (!got) chk("t6_rvalid_timeout", 32'd0, 32'd1);
    chk("t6_second_rdata", rdata0, 32'hCAFE_F00D);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
